// File: rtl/stripe_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : stripe_scheduler
// Description : Deals a 32-bit word stream round-robin onto two lane holding
//               registers, each with its own valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module stripe_scheduler #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_2f,
    input  logic              reset,
    input  logic              enable,
    input  logic              realign,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              in_ready,
    output logic [DATA_W-1:0] lane0,
    output logic              valid0,
    input  logic              lane_ready0,
    output logic [DATA_W-1:0] lane1,
    output logic              valid1,
    input  logic              lane_ready1,
    output logic              next_lane,
    output logic [CNT_W-1:0]  word_count,
    output logic              busy
);

    localparam logic [1:0]       c_st_idle  = 2'd0;
    localparam logic [1:0]       c_st_run   = 2'd1;
    localparam logic [1:0]       c_st_align = 2'd2;
    localparam logic [CNT_W-1:0] c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_realign_pend;
    logic [DATA_W-1:0] r_lane0;
    logic [DATA_W-1:0] r_lane1;
    logic              r_valid0;
    logic              r_valid1;
    logic              r_next_lane;
    logic [CNT_W-1:0]  r_word_count;

    logic w_lane_free;
    logic w_accept;
    logic w_wr0;
    logic w_wr1;
    logic w_align_done;
    logic w_realign_req;

    // Only the lane the next word is destined for can stall the source.
    assign w_lane_free   = r_next_lane ? (!r_valid1 | lane_ready1)
                                       : (!r_valid0 | lane_ready0);
    assign in_ready      = reset & (r_state == c_st_run) & w_lane_free;
    assign w_accept      = valid_in & in_ready;
    assign w_wr0         = w_accept & !r_next_lane;
    assign w_wr1         = w_accept &  r_next_lane;
    assign w_align_done  = (r_state == c_st_align) & !r_valid0 & !r_valid1;
    assign w_realign_req = realign | r_realign_pend;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_realign_req) begin
                    w_state_nxt = c_st_align;
                end else if (enable) begin
                    w_state_nxt = c_st_run;
                end
            end
            c_st_run: begin
                if (w_realign_req) begin
                    w_state_nxt = c_st_align;
                end else if (!enable) begin
                    w_state_nxt = c_st_idle;
                end
            end
            c_st_align: begin
                if (w_align_done) begin
                    w_state_nxt = enable ? c_st_run : c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            r_state        <= c_st_idle;
            r_realign_pend <= 1'b0;
            r_lane0        <= '0;
            r_lane1        <= '0;
            r_valid0       <= 1'b0;
            r_valid1       <= 1'b0;
            r_next_lane    <= 1'b0;
            r_word_count   <= '0;
        end else begin
            r_state <= w_state_nxt;
            // A pulse landing on the ALIGN exit edge is replayed, never dropped.
            r_realign_pend <= (r_state == c_st_align) & realign & w_align_done;

            // Refill takes priority over drain so a lane never bubbles.
            if (w_wr0) begin
                r_lane0  <= data_in;
                r_valid0 <= 1'b1;
            end else if (lane_ready0) begin
                r_valid0 <= 1'b0;
            end

            if (w_wr1) begin
                r_lane1  <= data_in;
                r_valid1 <= 1'b1;
            end else if (lane_ready1) begin
                r_valid1 <= 1'b0;
            end

            if (w_align_done) begin
                r_next_lane <= 1'b0;
            end else if (w_accept) begin
                r_next_lane <= ~r_next_lane;
            end

            if (w_accept) begin
                r_word_count <= r_word_count + c_cnt_one;
            end
        end
    end

    assign lane0      = r_lane0;
    assign lane1      = r_lane1;
    assign valid0     = r_valid0;
    assign valid1     = r_valid1;
    assign next_lane  = r_next_lane;
    assign word_count = r_word_count;
    assign busy       = r_valid0 | r_valid1 | (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_stripe_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_stripe_scheduler
// Description : Directed vector bench for stripe_scheduler (default and 4-bit
//               counter instances driven in parallel).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stripe_scheduler;

    localparam bit H = 1'b1;
    localparam bit L = 1'b0;
    localparam int NVEC = 34;

    typedef struct {
        logic        en;
        logic        ra;
        logic        vin;
        logic [31:0] din;
        logic        r0;
        logic        r1;
        logic        ck;
        logic        rdy;
        logic        v0;
        logic [31:0] l0;
        logic        v1;
        logic [31:0] l1;
        logic        nl;
        logic [15:0] cnt;
    } vec_t;

    logic        clk_2f = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        realign = 1'b0;
    logic [31:0] data_in = 32'h0;
    logic        valid_in = 1'b0;
    logic        lane_ready0 = 1'b1;
    logic        lane_ready1 = 1'b1;

    logic        in_ready, valid0, valid1, next_lane, busy;
    logic [31:0] lane0, lane1;
    logic [15:0] word_count;

    logic        w_in_ready, w_valid0, w_valid1, w_next_lane, w_busy;
    logic [31:0] w_lane0, w_lane1;
    logic [3:0]  w_word_count;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs [NVEC];

    stripe_scheduler dut (
        .clk_2f(clk_2f), .reset(reset), .enable(enable), .realign(realign),
        .data_in(data_in), .valid_in(valid_in), .in_ready(in_ready),
        .lane0(lane0), .valid0(valid0), .lane_ready0(lane_ready0),
        .lane1(lane1), .valid1(valid1), .lane_ready1(lane_ready1),
        .next_lane(next_lane), .word_count(word_count), .busy(busy)
    );

    stripe_scheduler #(.DATA_W(32), .CNT_W(4)) dut_w (
        .clk_2f(clk_2f), .reset(reset), .enable(enable), .realign(realign),
        .data_in(data_in), .valid_in(valid_in), .in_ready(w_in_ready),
        .lane0(w_lane0), .valid0(w_valid0), .lane_ready0(lane_ready0),
        .lane1(w_lane1), .valid1(w_valid1), .lane_ready1(lane_ready1),
        .next_lane(w_next_lane), .word_count(w_word_count), .busy(w_busy)
    );

    always #5 clk_2f = ~clk_2f;

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        vecs[0]  = '{H,L,L,32'h0,       H,H,H,L, L,32'h0,       L,32'h0,       L,16'd0};
        // Streaming, lanes always ready
        vecs[1]  = '{H,L,H,32'hFFFFFFFF,H,H,H,H, H,32'hFFFFFFFF,L,32'h0,       H,16'd1};
        vecs[2]  = '{H,L,H,32'hFFFFFFFE,H,H,H,H, L,32'hFFFFFFFF,H,32'hFFFFFFFE,L,16'd2};
        vecs[3]  = '{H,L,H,32'hFFFFFFFD,H,H,H,H, H,32'hFFFFFFFD,L,32'hFFFFFFFE,H,16'd3};
        vecs[4]  = '{H,L,H,32'hFFFFFFFC,H,H,H,H, L,32'hFFFFFFFD,H,32'hFFFFFFFC,L,16'd4};
        vecs[5]  = '{H,L,L,32'h0,       H,H,H,H, L,32'hFFFFFFFD,L,32'hFFFFFFFC,L,16'd4};
        // Back-pressure on lane1
        vecs[6]  = '{H,L,H,32'h11111111,H,L,H,H, H,32'h11111111,L,32'hFFFFFFFC,H,16'd5};
        vecs[7]  = '{H,L,H,32'h22222222,H,L,H,H, L,32'h11111111,H,32'h22222222,L,16'd6};
        vecs[8]  = '{H,L,H,32'h33333333,H,L,H,H, H,32'h33333333,H,32'h22222222,H,16'd7};
        vecs[9]  = '{H,L,H,32'h44444444,H,L,H,L, L,32'h33333333,H,32'h22222222,H,16'd7};
        vecs[10] = '{H,L,H,32'h44444444,H,L,H,L, L,32'h33333333,H,32'h22222222,H,16'd7};
        vecs[11] = '{H,L,H,32'h44444444,H,H,H,H, L,32'h33333333,H,32'h44444444,L,16'd8};
        vecs[12] = '{H,L,L,32'h0,       H,H,H,H, L,32'h33333333,L,32'h44444444,L,16'd8};
        // Enable drop with lane0 stalled, then resume on lane1
        vecs[13] = '{H,L,H,32'h55555555,L,H,H,H, H,32'h55555555,L,32'h44444444,H,16'd9};
        vecs[14] = '{L,L,L,32'h0,       L,H,L,L, H,32'h55555555,L,32'h44444444,H,16'd9};
        vecs[15] = '{L,L,H,32'h66666666,L,H,H,L, H,32'h55555555,L,32'h44444444,H,16'd9};
        vecs[16] = '{L,L,H,32'h66666666,H,H,H,L, L,32'h55555555,L,32'h44444444,H,16'd9};
        vecs[17] = '{L,L,H,32'h66666666,H,H,H,L, L,32'h55555555,L,32'h44444444,H,16'd9};
        vecs[18] = '{L,L,H,32'h66666666,H,H,H,L, L,32'h55555555,L,32'h44444444,H,16'd9};
        vecs[19] = '{L,L,H,32'h66666666,H,H,H,L, L,32'h55555555,L,32'h44444444,H,16'd9};
        vecs[20] = '{H,L,H,32'h66666666,H,H,H,L, L,32'h55555555,L,32'h44444444,H,16'd9};
        vecs[21] = '{H,L,H,32'h66666666,H,H,H,H, L,32'h55555555,H,32'h66666666,L,16'd10};
        vecs[22] = '{H,L,L,32'h0,       H,H,H,H, L,32'h55555555,L,32'h66666666,L,16'd10};
        // Realign with lane0 stalled
        vecs[23] = '{H,L,H,32'h77777777,H,H,H,H, H,32'h77777777,L,32'h66666666,H,16'd11};
        vecs[24] = '{H,L,H,32'h88888888,H,H,H,H, L,32'h77777777,H,32'h88888888,L,16'd12};
        vecs[25] = '{H,L,H,32'h99999999,L,H,H,H, H,32'h99999999,L,32'h88888888,H,16'd13};
        vecs[26] = '{H,H,L,32'h0,       L,H,H,H, H,32'h99999999,L,32'h88888888,H,16'd13};
        vecs[27] = '{H,L,H,32'hAAAAAAAA,L,H,H,L, H,32'h99999999,L,32'h88888888,H,16'd13};
        vecs[28] = '{H,L,H,32'hAAAAAAAA,L,H,H,L, H,32'h99999999,L,32'h88888888,H,16'd13};
        vecs[29] = '{H,L,H,32'hAAAAAAAA,L,H,H,L, H,32'h99999999,L,32'h88888888,H,16'd13};
        vecs[30] = '{H,L,H,32'hAAAAAAAA,H,H,H,L, L,32'h99999999,L,32'h88888888,H,16'd13};
        vecs[31] = '{H,L,H,32'hAAAAAAAA,H,H,H,L, L,32'h99999999,L,32'h88888888,L,16'd13};
        vecs[32] = '{H,L,H,32'hAAAAAAAA,H,H,H,H, H,32'hAAAAAAAA,L,32'h88888888,H,16'd14};
        vecs[33] = '{H,L,L,32'h0,       H,H,H,H, L,32'hAAAAAAAA,L,32'h88888888,H,16'd14};

        // Reset held for two edges
        @(posedge clk_2f);
        @(posedge clk_2f);
        #1;
        chk("rst_valid0", 0, {31'b0, valid0}, 32'd0);
        chk("rst_valid1", 0, {31'b0, valid1}, 32'd0);
        chk("rst_count", 0, {16'b0, word_count}, 32'd0);
        chk("rst_next_lane", 0, {31'b0, next_lane}, 32'd0);
        chk("rst_in_ready", 0, {31'b0, in_ready}, 32'd0);
        chk("rst_busy", 0, {31'b0, busy}, 32'd0);
        @(negedge clk_2f);
        reset = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk_2f);
            enable      = vecs[i].en;
            realign     = vecs[i].ra;
            valid_in    = vecs[i].vin;
            data_in     = vecs[i].din;
            lane_ready0 = vecs[i].r0;
            lane_ready1 = vecs[i].r1;
            #1;
            if (vecs[i].ck) chk("in_ready", i, {31'b0, in_ready}, {31'b0, vecs[i].rdy});
            @(posedge clk_2f);
            #1;
            chk("valid0", i, {31'b0, valid0}, {31'b0, vecs[i].v0});
            chk("lane0", i, lane0, vecs[i].l0);
            chk("valid1", i, {31'b0, valid1}, {31'b0, vecs[i].v1});
            chk("lane1", i, lane1, vecs[i].l1);
            chk("next_lane", i, {31'b0, next_lane}, {31'b0, vecs[i].nl});
            chk("word_count", i, {16'b0, word_count}, {16'b0, vecs[i].cnt});
            chk("word_count4", i, {28'b0, w_word_count}, {28'b0, vecs[i].cnt[3:0]});
        end

        // Counter wrap: 17 words from a clean reset
        @(negedge clk_2f);
        reset    = 1'b0;
        enable   = 1'b0;
        realign  = 1'b0;
        valid_in = 1'b0;
        lane_ready0 = 1'b1;
        lane_ready1 = 1'b1;
        @(posedge clk_2f);
        @(negedge clk_2f);
        reset  = 1'b1;
        enable = 1'b1;
        for (int k = 0; k < 17; k++) begin
            @(negedge clk_2f);
            valid_in = 1'b1;
            data_in  = 32'h1000 + k;
            #1;
            chk("burst_in_ready", k, {31'b0, in_ready}, 32'd1);
        end
        @(negedge clk_2f);
        valid_in = 1'b0;
        #1;
        chk("wrap_count16", 17, {16'b0, word_count}, 32'd17);
        chk("wrap_count4", 17, {28'b0, w_word_count}, 32'd1);
        chk("wrap_next_lane", 17, {31'b0, next_lane}, 32'd1);

        // Async reset with a word in flight, between clock edges
        @(negedge clk_2f);
        lane_ready0 = 1'b0;
        lane_ready1 = 1'b0;
        valid_in    = 1'b1;
        data_in     = 32'hDEADBEEF;
        @(posedge clk_2f);
        #1;
        chk("inflight_valid1", 0, {31'b0, valid1}, 32'd1);
        chk("inflight_lane1", 0, lane1, 32'hDEADBEEF);
        #1;
        reset = 1'b0;
        #1;
        chk("arst_valid0", 0, {31'b0, valid0}, 32'd0);
        chk("arst_valid1", 0, {31'b0, valid1}, 32'd0);
        chk("arst_lane0", 0, lane0, 32'd0);
        chk("arst_lane1", 0, lane1, 32'd0);
        chk("arst_count", 0, {16'b0, word_count}, 32'd0);
        chk("arst_count4", 0, {28'b0, w_word_count}, 32'd0);
        chk("arst_next_lane", 0, {31'b0, next_lane}, 32'd0);
        chk("arst_in_ready", 0, {31'b0, in_ready}, 32'd0);
        chk("arst_busy", 0, {31'b0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
